escalonador_hamming: RTL

ESCALONADOR_HAMMING -- requirements
Module: escalonador_hamming

---
 rtl/hamming_pkg.sv | 20 ++
 rtl/calcula_hamming.sv | 27 ++
 rtl/escalonador_hamming.sv | 106 ++++++++++
 3 files changed

// File: rtl/hamming_pkg.sv
// Shared constants and types for the Hamming serialiser.
// HAMMING_PARIDADE_GLOBAL_EN adds an overall parity bit s15, which makes a 16-bit SECDED frame.
package hamming_pkg;

  localparam int N_DADOS  = 11;
  localparam int N_CODIGO = 15;
  localparam int CNT_W    = 5;

`ifdef HAMMING_PARIDADE_GLOBAL_EN
  localparam int N_QUADRO = N_CODIGO + 1;
`else
  localparam int N_QUADRO = N_CODIGO;
`endif

  typedef enum logic {
    OCIOSO = 1'b0,
    ENVIO  = 1'b1
  } estado_t;

endpackage

// File: rtl/calcula_hamming.sv
// Combinational Hamming(15,11) encoder. s0 is the first bit sent.
// HAMMING_PARIDADE_GLOBAL_EN appends the even parity of s0..s14 as s15.
module calcula_hamming
  import hamming_pkg::*;
(
  input  logic [N_DADOS-1:0]  dado_i,
  output logic [N_QUADRO-1:0] codigo_o
);

  logic                p1, p2, p4, p8;
  logic [N_CODIGO-1:0] base;

  // Each check bit covers the codeword positions (1-based) whose index has that bit set.
  assign p1 = dado_i[0] ^ dado_i[1] ^ dado_i[3] ^ dado_i[4] ^ dado_i[6] ^ dado_i[8] ^ dado_i[10];
  assign p2 = dado_i[0] ^ dado_i[2] ^ dado_i[3] ^ dado_i[5] ^ dado_i[6] ^ dado_i[9] ^ dado_i[10];
  assign p4 = dado_i[1] ^ dado_i[2] ^ dado_i[3] ^ dado_i[7] ^ dado_i[8] ^ dado_i[9] ^ dado_i[10];
  assign p8 = dado_i[4] ^ dado_i[5] ^ dado_i[6] ^ dado_i[7] ^ dado_i[8] ^ dado_i[9] ^ dado_i[10];

  assign base = {dado_i[10:4], p8, dado_i[3:1], p4, dado_i[0], p2, p1};

`ifdef HAMMING_PARIDADE_GLOBAL_EN
  assign codigo_o = {^base, base};
`else
  assign codigo_o = base;
`endif

endmodule

// File: rtl/escalonador_hamming.sv
// Two-requester arbiter that Hamming-encodes the granted word and sends it out serially, LSB first.
// HAMMING_PARIDADE_GLOBAL_EN (see hamming_pkg) selects a 16-bit frame instead of a 15-bit one.
module escalonador_hamming
  import hamming_pkg::*;
#(
  parameter int PRIO_FIXA = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  input  logic [N_DADOS-1:0] req0_dado,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [N_DADOS-1:0] req1_dado,
  output logic               req1_ready,
  output logic               tx_bit,
  output logic               tx_valid,
  output logic               tx_inicio,
  output logic               tx_fonte,
  output logic               ocupado
);

  localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(N_QUADRO - 1);

  estado_t               estado_q;
  logic                  ptr_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [N_QUADRO-1:0]   shift_q;
  logic                  fonte_q;
  logic                  inicio_q;

  logic                  grant0, grant1;
  logic                  ocioso;
  logic                  transfer;
  logic [N_DADOS-1:0]    dado_sel;
  logic [N_QUADRO-1:0]   codigo;

  // ptr_q names the requester that wins when both are valid.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (PRIO_FIXA != 0) begin
      grant0 = req0_valid;
      grant1 = req1_valid & ~req0_valid;
    end else begin
      grant0 = req0_valid & (~req1_valid | ~ptr_q);
      grant1 = req1_valid & (~req0_valid | ptr_q);
    end
  end

  assign ocioso     = (estado_q == OCIOSO) & ~rst;
  assign req0_ready = ocioso & grant0;
  assign req1_ready = ocioso & grant1;
  assign transfer   = req0_ready | req1_ready;
  assign dado_sel   = grant1 ? req1_dado : req0_dado;

  calcula_hamming u_calcula_hamming (
    .dado_i   (dado_sel),
    .codigo_o (codigo)
  );

  // The shift register is cleared at the end of each frame, so tx_bit is 0 while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q <= OCIOSO;
      ptr_q    <= 1'b0;
      cnt_q    <= '0;
      shift_q  <= '0;
      fonte_q  <= 1'b0;
      inicio_q <= 1'b0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (transfer) begin
            estado_q <= ENVIO;
            shift_q  <= codigo;
            fonte_q  <= grant1;
            ptr_q    <= grant0;
            cnt_q    <= '0;
            inicio_q <= 1'b1;
          end
        end
        ENVIO: begin
          inicio_q <= 1'b0;
          if (cnt_q == ULTIMO) begin
            estado_q <= OCIOSO;
            cnt_q    <= '0;
            shift_q  <= '0;
            fonte_q  <= 1'b0;
          end else begin
            cnt_q    <= cnt_q + 1'b1;
            shift_q  <= shift_q >> 1;
          end
        end
        default: estado_q <= OCIOSO;
      endcase
    end
  end

  assign tx_bit    = shift_q[0];
  assign tx_valid  = (estado_q == ENVIO);
  assign tx_inicio = inicio_q;
  assign tx_fonte  = fonte_q;
  assign ocupado   = (estado_q != OCIOSO);

endmodule
